plru4_miss_ctrl: RTL

//  Miss-handling / way-allocation controller sitting directly upstream of the per-set 4-way PLRU.

---
 rtl/plru4_miss_ctrl_if.sv | 64 ++++++
 rtl/plru4_miss_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/plru4_miss_ctrl_if.sv
// -----------------------------------------------------------------------------
// plru4_miss_ctrl_if
//   Bundles every handshake/bus signal of the PLRU miss controller.
//   Names keep the controller's point of view (i_* into it, o_* out of it).
//   Modports:
//     slave  : the miss controller (consumes i_*, drives o_*)
//     master : the environment (lookup pipe, PLRU, write-back and refill
//              engines) which drives i_* and observes o_*
// Ports summary:
//   lookup   : i_lkup_vld/o_lkup_rdy, i_lkup_set, i_lkup_hit, i_lkup_hit_way,
//              i_lkup_wr, i_flush
//   PLRU     : o_plru_set, o_plru_hit, o_plru_hit_idx, o_plru_req,
//              i_plru_replace_idx
//   wb       : o_wb_vld/i_wb_rdy, o_wb_set, o_wb_way
//   refill   : o_rf_vld/i_rf_rdy, o_rf_set, o_rf_way, i_rf_done
//   complete : o_done_vld, o_done_way
// -----------------------------------------------------------------------------
interface plru4_miss_ctrl_if #(
  parameter int SET_W = 6
) ();
  logic             i_lkup_vld;
  logic             o_lkup_rdy;
  logic [SET_W-1:0] i_lkup_set;
  logic             i_lkup_hit;
  logic [1:0]       i_lkup_hit_way;
  logic             i_lkup_wr;
  logic             i_flush;

  logic [SET_W-1:0] o_plru_set;
  logic             o_plru_hit;
  logic [1:0]       o_plru_hit_idx;
  logic             o_plru_req;
  logic [1:0]       i_plru_replace_idx;

  logic             o_wb_vld;
  logic             i_wb_rdy;
  logic [SET_W-1:0] o_wb_set;
  logic [1:0]       o_wb_way;

  logic             o_rf_vld;
  logic             i_rf_rdy;
  logic [SET_W-1:0] o_rf_set;
  logic [1:0]       o_rf_way;
  logic             i_rf_done;

  logic             o_done_vld;
  logic [1:0]       o_done_way;

  modport slave (
    input  i_lkup_vld, i_lkup_set, i_lkup_hit, i_lkup_hit_way, i_lkup_wr, i_flush,
    input  i_plru_replace_idx, i_wb_rdy, i_rf_rdy, i_rf_done,
    output o_lkup_rdy, o_plru_set, o_plru_hit, o_plru_hit_idx, o_plru_req,
    output o_wb_vld, o_wb_set, o_wb_way, o_rf_vld, o_rf_set, o_rf_way,
    output o_done_vld, o_done_way
  );

  modport master (
    output i_lkup_vld, i_lkup_set, i_lkup_hit, i_lkup_hit_way, i_lkup_wr, i_flush,
    output i_plru_replace_idx, i_wb_rdy, i_rf_rdy, i_rf_done,
    input  o_lkup_rdy, o_plru_set, o_plru_hit, o_plru_hit_idx, o_plru_req,
    input  o_wb_vld, o_wb_set, o_wb_way, o_rf_vld, o_rf_set, o_rf_way,
    input  o_done_vld, o_done_way
  );
endinterface

// File: rtl/plru4_miss_ctrl.sv
// -----------------------------------------------------------------------------
// plru4_miss_ctrl
//   Miss-handling / way-allocation controller in front of a per-set 4-way
//   PLRU. Takes tag-lookup results, keeps per-set valid/dirty bits, strobes
//   the PLRU (touch on hit, victim request on miss), and sequences dirty
//   write-back, refill and completion. One miss in flight; the lookup port
//   is blocked while busy.
// Ports:
//   clk  : clock
//   rst  : asynchronous reset, active-high
//   bus  : plru4_miss_ctrl_if.slave (lookup, PLRU, write-back, refill and
//          completion signals)
// Configuration macro:
//   PLRU4_INVALID_FIRST_EN : when defined, a miss allocates the lowest
//   invalid way of the set (announced with a PLRU touch) instead of asking
//   the PLRU for a victim; with all ways valid the PLRU request is used.
// -----------------------------------------------------------------------------
module plru4_miss_ctrl #(
  parameter int SETS  = 64,
  parameter int SET_W = $clog2(SETS)
) (
  input logic               clk,
  input logic               rst,
  plru4_miss_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, HIT, VICT, WB, RF, RFW} state_t;

  state_t           state_reg;
  logic [SET_W-1:0] set_reg;       // set of the access in flight
  logic [1:0]       way_reg;       // hit way, then victim way
  logic             wr_reg;        // access is a store
  logic             plru_hit_reg;
  logic             plru_req_reg;
  logic             wb_vld_reg;
  logic             rf_vld_reg;
  logic             done_vld_reg;
`ifdef PLRU4_INVALID_FIRST_EN
  logic             pick_inv_reg;  // victim came from the invalid-way scan
`endif

  // Per-set state bits, flattened for lookup by set index.
  logic [SETS-1:0][3:0] valid_all;
  logic [SETS-1:0][3:0] dirty_all;

  logic accept;
  logic flush_clr;
  logic victim_dirty;

  // Single-entry write command into the per-set bit storage.
  logic bit_we_v;
  logic bit_we_d;
  logic bit_v;
  logic bit_d;

  assign bus.o_lkup_rdy = (state_reg == IDLE) & ~rst & ~bus.i_flush;
  assign accept         = bus.i_lkup_vld & bus.o_lkup_rdy;
  assign flush_clr      = (state_reg == IDLE) & bus.i_flush;

  // The PLRU victim is combinational and only meaningful during VICT.
  assign victim_dirty = valid_all[set_reg][bus.i_plru_replace_idx] &
                        dirty_all[set_reg][bus.i_plru_replace_idx];

`ifdef PLRU4_INVALID_FIRST_EN
  function automatic logic [1:0] first_inv(input logic [3:0] v);
    first_inv = 2'd0;
    for (int w = 3; w >= 0; w--) begin
      if (!v[w]) first_inv = 2'(w);
    end
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Bit update command derived from the current state.
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_we_v = 1'b0;
    bit_we_d = 1'b0;
    bit_v    = 1'b0;
    bit_d    = 1'b0;
    case (state_reg)
      HIT: begin
        // Store hit: dirty |= wr
        bit_we_d = wr_reg;
        bit_d    = 1'b1;
      end
      WB: begin
        // Line leaves the cache once the write-back is accepted
        if (bus.i_wb_rdy) begin
          bit_we_v = 1'b1;
          bit_we_d = 1'b1;
        end
      end
      RF: begin
        if (bus.i_rf_rdy && bus.i_rf_done) begin
          bit_we_v = 1'b1;
          bit_we_d = 1'b1;
          bit_v    = 1'b1;
          bit_d    = wr_reg;
        end
      end
      RFW: begin
        if (bus.i_rf_done) begin
          bit_we_v = 1'b1;
          bit_we_d = 1'b1;
          bit_v    = 1'b1;
          bit_d    = wr_reg;
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-set valid/dirty storage. Kept in flops so a flush clears every set in
  // a single cycle.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SETS; gi++) begin : g_set
      logic [3:0] valid_reg;
      logic [3:0] dirty_reg;
      logic       sel;

      assign sel = (set_reg == SET_W'(gi));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= '0;
          dirty_reg <= '0;
        end else if (flush_clr) begin
          valid_reg <= '0;
          dirty_reg <= '0;
        end else if (sel) begin
          if (bit_we_v) valid_reg[way_reg] <= bit_v;
          if (bit_we_d) dirty_reg[way_reg] <= bit_d;
        end
      end

      assign valid_all[gi] = valid_reg;
      assign dirty_all[gi] = dirty_reg;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. Strobes default low so each PLRU
  // strobe and the completion flag are single-cycle pulses.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      set_reg      <= '0;
      way_reg      <= '0;
      wr_reg       <= 1'b0;
      plru_hit_reg <= 1'b0;
      plru_req_reg <= 1'b0;
      wb_vld_reg   <= 1'b0;
      rf_vld_reg   <= 1'b0;
      done_vld_reg <= 1'b0;
`ifdef PLRU4_INVALID_FIRST_EN
      pick_inv_reg <= 1'b0;
`endif
    end else begin
      plru_hit_reg <= 1'b0;
      plru_req_reg <= 1'b0;
      done_vld_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (accept) begin
            set_reg <= bus.i_lkup_set;
            wr_reg  <= bus.i_lkup_wr;
            if (bus.i_lkup_hit) begin
              // Touch and completion are visible in the HIT cycle.
              way_reg      <= bus.i_lkup_hit_way;
              plru_hit_reg <= 1'b1;
              done_vld_reg <= 1'b1;
              state_reg    <= HIT;
            end else begin
`ifdef PLRU4_INVALID_FIRST_EN
              if (~&valid_all[bus.i_lkup_set]) begin
                way_reg      <= first_inv(valid_all[bus.i_lkup_set]);
                plru_hit_reg <= 1'b1;
                pick_inv_reg <= 1'b1;
              end else begin
                plru_req_reg <= 1'b1;
                pick_inv_reg <= 1'b0;
              end
`else
              plru_req_reg <= 1'b1;
`endif
              state_reg <= VICT;
            end
          end
        end

        HIT: state_reg <= IDLE;

        VICT: begin
`ifdef PLRU4_INVALID_FIRST_EN
          if (pick_inv_reg) begin
            // Invalid way already chosen; nothing to write back.
            rf_vld_reg <= 1'b1;
            state_reg  <= RF;
          end else
`endif
          begin
            way_reg <= bus.i_plru_replace_idx;
            if (victim_dirty) begin
              wb_vld_reg <= 1'b1;
              state_reg  <= WB;
            end else begin
              rf_vld_reg <= 1'b1;
              state_reg  <= RF;
            end
          end
        end

        WB: begin
          if (bus.i_wb_rdy) begin
            wb_vld_reg <= 1'b0;
            rf_vld_reg <= 1'b1;
            state_reg  <= RF;
          end
        end

        RF: begin
          if (bus.i_rf_rdy) begin
            rf_vld_reg <= 1'b0;
            if (bus.i_rf_done) begin
              done_vld_reg <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              state_reg <= RFW;
            end
          end
        end

        RFW: begin
          if (bus.i_rf_done) begin
            done_vld_reg <= 1'b1;
            state_reg    <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  // Target set/way fields all follow the in-flight access registers; they
  // only carry meaning while the matching strobe/valid is high.
  assign bus.o_plru_set     = set_reg;
  assign bus.o_plru_hit     = plru_hit_reg;
  assign bus.o_plru_hit_idx = way_reg;
  assign bus.o_plru_req     = plru_req_reg;
  assign bus.o_wb_vld       = wb_vld_reg;
  assign bus.o_wb_set       = set_reg;
  assign bus.o_wb_way       = way_reg;
  assign bus.o_rf_vld       = rf_vld_reg;
  assign bus.o_rf_set       = set_reg;
  assign bus.o_rf_way       = way_reg;
  assign bus.o_done_vld     = done_vld_reg;
  assign bus.o_done_way     = way_reg;

endmodule
